// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory loads/stores over a req/ack handshake with
// big-endian byte-lane alignment, sign extension and the MEM/WB register.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | no access outstanding; non-memory ops pass to WB in one cycle
//  ACCESS | request on the bus from latched copies; wait for dmem_ack_i
module mem_wb_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       EXMEM_alu_result_i,
    input  logic [31:0]       EXMEM_b_i,
    input  logic [4:0]        EXMEM_rd_i,
    input  logic [1:0]        EXMEM_ctrl_mem_read_i,
    input  logic [1:0]        EXMEM_ctrl_mem_write_i,
    input  logic              EXMEM_ctrl_reg_write_i,
    input  logic              EXMEM_ctrl_mem_to_reg_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic [4:0]        WB_reg_write_address_o,
    output logic [31:0]       WB_reg_write_data_o,
    output logic              WB_ctrl_reg_write_o,
    output logic              MEM_stall_o,
    output logic              MEM_misalign_o
);

    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state;

    logic        is_read;
    logic        is_write;
    logic [1:0]  size;
    logic        mem_op;
    logic [1:0]  offset;
    logic        aligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    logic [31:0] lat_alu;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_we;
    logic [4:0]  lat_rd;
    logic        lat_reg_write;
    logic        lat_is_read;
    logic        lat_mem_to_reg;
    logic [1:0]  lat_size;

    logic [15:0] lane_half;
    logic [7:0]  lane_byte;
    logic [31:0] load_data;

    // Decode the incoming op: size, alignment, byte enables and replicated store data.
    // A read with a nonzero write field is still a read.
    always_comb begin
        is_read    = (EXMEM_ctrl_mem_read_i != 2'b00);
        is_write   = (EXMEM_ctrl_mem_write_i != 2'b00) && !is_read;
        size       = is_read ? EXMEM_ctrl_mem_read_i : EXMEM_ctrl_mem_write_i;
        mem_op     = is_read || is_write;
        offset     = EXMEM_alu_result_i[1:0];
        aligned    = 1'b1;
        be_next    = 4'b0000;
        wdata_next = EXMEM_b_i;
        case (size)
            SZ_WORD: begin
                aligned    = (offset == 2'b00);
                be_next    = 4'b1111;
                wdata_next = EXMEM_b_i;
            end
            SZ_HALF: begin
                aligned    = !offset[0];
                be_next    = offset[1] ? 4'b0011 : 4'b1100;
                wdata_next = {2{EXMEM_b_i[15:0]}};
            end
            SZ_BYTE: begin
                aligned    = 1'b1;
                be_next    = 4'b1000 >> offset;
                wdata_next = {4{EXMEM_b_i[7:0]}};
            end
            default: begin
                aligned    = 1'b1;
                be_next    = 4'b0000;
                wdata_next = EXMEM_b_i;
            end
        endcase
    end

    // Pick the addressed lane of the returned word (offset 0 = MSBs) and sign-extend.
    always_comb begin
        lane_half = lat_alu[1] ? dmem_rdata_i[15:0] : dmem_rdata_i[31:16];
        case (lat_alu[1:0])
            2'd0:    lane_byte = dmem_rdata_i[31:24];
            2'd1:    lane_byte = dmem_rdata_i[23:16];
            2'd2:    lane_byte = dmem_rdata_i[15:8];
            default: lane_byte = dmem_rdata_i[7:0];
        endcase
        case (lat_size)
            SZ_HALF: load_data = {{16{lane_half[15]}}, lane_half};
            SZ_BYTE: load_data = {{24{lane_byte[7]}}, lane_byte};
            default: load_data = dmem_rdata_i;
        endcase
    end

    // FSM, access latches and the MEM/WB register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                  <= IDLE;
            lat_alu                <= '0;
            lat_wdata              <= '0;
            lat_be                 <= '0;
            lat_we                 <= 1'b0;
            lat_rd                 <= '0;
            lat_reg_write          <= 1'b0;
            lat_is_read            <= 1'b0;
            lat_mem_to_reg         <= 1'b0;
            lat_size               <= '0;
            WB_reg_write_address_o <= '0;
            WB_reg_write_data_o    <= '0;
            WB_ctrl_reg_write_o    <= 1'b0;
            MEM_misalign_o         <= 1'b0;
        end else begin
            MEM_misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op && aligned) begin
                        lat_alu             <= EXMEM_alu_result_i;
                        lat_wdata           <= wdata_next;
                        lat_be              <= be_next;
                        lat_we              <= is_write;
                        lat_rd              <= EXMEM_rd_i;
                        lat_reg_write       <= EXMEM_ctrl_reg_write_i;
                        lat_is_read         <= is_read;
                        lat_mem_to_reg      <= EXMEM_ctrl_mem_to_reg_i;
                        lat_size            <= size;
                        WB_ctrl_reg_write_o <= 1'b0;
                        state               <= ACCESS;
                    end else begin
                        // Non-memory op completes here; a misaligned access is
                        // squashed and only flagged.
                        WB_reg_write_address_o <= EXMEM_rd_i;
                        WB_reg_write_data_o    <= EXMEM_alu_result_i;
                        WB_ctrl_reg_write_o    <= !mem_op && EXMEM_ctrl_reg_write_i
                                                  && (EXMEM_rd_i != 5'd0);
                        MEM_misalign_o         <= mem_op;
                    end
                end
                ACCESS: begin
                    if (dmem_ack_i) begin
                        WB_reg_write_address_o <= lat_rd;
                        WB_reg_write_data_o    <= (lat_is_read || lat_mem_to_reg)
                                                  ? load_data : lat_alu;
                        WB_ctrl_reg_write_o    <= lat_is_read && lat_reg_write
                                                  && (lat_rd != 5'd0);
                        state                  <= IDLE;
                    end else begin
                        WB_ctrl_reg_write_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus side is driven only from latched copies so it stays stable until ack.
    always_comb begin
        dmem_req_o   = (state == ACCESS);
        dmem_we_o    = (state == ACCESS) && lat_we;
        dmem_be_o    = (state == ACCESS) ? lat_be : 4'b0000;
        dmem_addr_o  = {lat_alu[ADDR_W-1:2], 2'b00};
        dmem_wdata_o = lat_wdata;
    end

    // Hold upstream while an aligned access is starting or still waiting for ack.
    always_comb begin
        MEM_stall_o = !rst_i &&
                      (((state == IDLE) && mem_op && aligned) ||
                       ((state == ACCESS) && !dmem_ack_i));
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: inputs change on the falling edge,
// registered outputs are sampled 1 ns after the rising edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_rw;
    logic        stall;
    logic        misalign;

    int vectors    = 0;
    int miscompares = 0;

    mem_wb_stage #(.ADDR_W(32)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .EXMEM_alu_result_i      (alu_result),
        .EXMEM_b_i               (b),
        .EXMEM_rd_i              (rd),
        .EXMEM_ctrl_mem_read_i   (mem_read),
        .EXMEM_ctrl_mem_write_i  (mem_write),
        .EXMEM_ctrl_reg_write_i  (reg_write),
        .EXMEM_ctrl_mem_to_reg_i (mem_to_reg),
        .dmem_req_o              (req),
        .dmem_we_o               (we),
        .dmem_addr_o             (addr),
        .dmem_be_o               (be),
        .dmem_wdata_o            (wdata),
        .dmem_ack_i              (ack),
        .dmem_rdata_i            (rdata),
        .WB_reg_write_address_o  (wb_addr),
        .WB_reg_write_data_o     (wb_data),
        .WB_ctrl_reg_write_o     (wb_rw),
        .MEM_stall_o             (stall),
        .MEM_misalign_o          (misalign)
    );

    always #5 clk = ~clk;

    // Load vectors: address, size, mem_to_reg, returned word, expected be / bus address / WB data.
    localparam logic [31:0] LD_ADDR  [5] = '{32'h100, 32'h203, 32'h202, 32'h200, 32'h200};
    localparam logic [1:0]  LD_SIZE  [5] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b10};
    localparam logic        LD_M2R   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] LD_RDATA [5] = '{32'hDEADBEEF, 32'h11223380, 32'h11227FFF,
                                             32'h7F000000, 32'h80010000};
    localparam logic [3:0]  LD_BE    [5] = '{4'b1111, 4'b0001, 4'b0011, 4'b1000, 4'b1100};
    localparam logic [31:0] LD_BUS   [5] = '{32'h100, 32'h200, 32'h200, 32'h200, 32'h200};
    localparam logic [31:0] LD_EXP   [5] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00007FFF,
                                             32'h0000007F, 32'hFFFF8001};

    // Store vectors with immediate ack.
    localparam logic [31:0] ST_ADDR  [3] = '{32'h001, 32'h020, 32'h010};
    localparam logic [1:0]  ST_SIZE  [3] = '{2'b11, 2'b01, 2'b10};
    localparam logic [31:0] ST_DATA  [3] = '{32'h123456A5, 32'hCAFEF00D, 32'hFFFF1234};
    localparam logic [3:0]  ST_BE    [3] = '{4'b0100, 4'b1111, 4'b1100};
    localparam logic [31:0] ST_BUS   [3] = '{32'h000, 32'h020, 32'h010};
    localparam logic [31:0] ST_WDATA [3] = '{32'hA5A5A5A5, 32'hCAFEF00D, 32'h12341234};

    task automatic clear_inputs();
        alu_result = '0; b = '0; rd = '0;
        mem_read = 2'b00; mem_write = 2'b00;
        reg_write = 1'b0; mem_to_reg = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ack = 1'b0; rdata = '0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (req !== 1'b0)   begin miscompares++; $display("FAIL reset req: got %b expected 0", req); end
        vectors++; if (we !== 1'b0)    begin miscompares++; $display("FAIL reset we: got %b expected 0", we); end
        vectors++; if (be !== 4'b0)    begin miscompares++; $display("FAIL reset be: got %b expected 0000", be); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset stall: got %b expected 0", stall); end
        vectors++; if (wb_rw !== 1'b0) begin miscompares++; $display("FAIL reset wb_rw: got %b expected 0", wb_rw); end
        vectors++; if (wb_data !== 32'h0) begin miscompares++; $display("FAIL reset wb_data: got %h expected 0", wb_data); end
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL reset misalign: got %b expected 0", misalign); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        @(negedge clk);
        alu_result = 32'h0000_1234; rd = 5'd5; reg_write = 1'b1;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        vectors++; if (wb_addr !== 5'd5) begin miscompares++; $display("FAIL alu wb_addr: got %0d expected 5", wb_addr); end
        vectors++; if (wb_data !== 32'h1234) begin miscompares++; $display("FAIL alu wb_data: got %h expected 00001234", wb_data); end
        vectors++; if (wb_rw !== 1'b1) begin miscompares++; $display("FAIL alu wb_rw: got %b expected 1", wb_rw); end
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL alu req: got %b expected 0", req); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_loads();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            alu_result = LD_ADDR[i]; rd = 5'(7 + i); mem_read = LD_SIZE[i];
            reg_write = 1'b1; mem_to_reg = LD_M2R[i]; ack = 1'b0;
            #1;
            vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL ld[%0d] idle stall: got %b expected 1", i, stall); end
            vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL ld[%0d] idle req: got %b expected 0", i, req); end
            @(posedge clk); #1;
            vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL ld[%0d] req: got %b expected 1", i, req); end
            vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL ld[%0d] we: got %b expected 0", i, we); end
            vectors++; if (be !== LD_BE[i]) begin miscompares++; $display("FAIL ld[%0d] be: got %b expected %b", i, be, LD_BE[i]); end
            vectors++; if (addr !== LD_BUS[i]) begin miscompares++; $display("FAIL ld[%0d] addr: got %h expected %h", i, addr, LD_BUS[i]); end
            vectors++; if (wb_rw !== 1'b0) begin miscompares++; $display("FAIL ld[%0d] bubble wb_rw: got %b expected 0", i, wb_rw); end
            ack = 1'b1; rdata = LD_RDATA[i];
            #1;
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL ld[%0d] ack stall: got %b expected 0", i, stall); end
            @(posedge clk); #1;
            vectors++; if (wb_data !== LD_EXP[i]) begin miscompares++; $display("FAIL ld[%0d] wb_data: got %h expected %h", i, wb_data, LD_EXP[i]); end
            vectors++; if (wb_addr !== 5'(7 + i)) begin miscompares++; $display("FAIL ld[%0d] wb_addr: got %0d expected %0d", i, wb_addr, 7 + i); end
            vectors++; if (wb_rw !== 1'b1) begin miscompares++; $display("FAIL ld[%0d] wb_rw: got %b expected 1", i, wb_rw); end
            vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL ld[%0d] req after ack: got %b expected 0", i, req); end
            @(negedge clk);
            ack = 1'b0;
            clear_inputs();
        end
    endtask

    task automatic test_stores();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alu_result = ST_ADDR[i]; b = ST_DATA[i]; rd = 5'd4;
            mem_write = ST_SIZE[i]; reg_write = 1'b1; ack = 1'b0;
            @(posedge clk); #1;
            vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL st[%0d] we: got %b expected 1", i, we); end
            vectors++; if (be !== ST_BE[i]) begin miscompares++; $display("FAIL st[%0d] be: got %b expected %b", i, be, ST_BE[i]); end
            vectors++; if (addr !== ST_BUS[i]) begin miscompares++; $display("FAIL st[%0d] addr: got %h expected %h", i, addr, ST_BUS[i]); end
            vectors++; if (wdata !== ST_WDATA[i]) begin miscompares++; $display("FAIL st[%0d] wdata: got %h expected %h", i, wdata, ST_WDATA[i]); end
            ack = 1'b1;
            @(posedge clk); #1;
            vectors++; if (wb_rw !== 1'b0) begin miscompares++; $display("FAIL st[%0d] wb_rw: got %b expected 0", i, wb_rw); end
            vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL st[%0d] req after ack: got %b expected 0", i, req); end
            @(negedge clk);
            ack = 1'b0;
            clear_inputs();
        end
    endtask

    task automatic test_store_wait();
        @(negedge clk);
        alu_result = 32'h12; b = 32'h0000_ABCD; rd = 5'd3; mem_write = 2'b10; ack = 1'b0;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL sh_wait idle stall: got %b expected 1", stall); end
        @(posedge clk); #1;
        // Inputs must not be re-sampled while the access is outstanding.
        alu_result = 32'h0000_0055; b = 32'h1111_2222;
        for (int c = 0; c < 3; c++) begin
            vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL sh_wait[%0d] req: got %b expected 1", c, req); end
            vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL sh_wait[%0d] we: got %b expected 1", c, we); end
            vectors++; if (be !== 4'b0011) begin miscompares++; $display("FAIL sh_wait[%0d] be: got %b expected 0011", c, be); end
            vectors++; if (wdata !== 32'hABCDABCD) begin miscompares++; $display("FAIL sh_wait[%0d] wdata: got %h expected abcdabcd", c, wdata); end
            vectors++; if (addr !== 32'h10) begin miscompares++; $display("FAIL sh_wait[%0d] addr: got %h expected 00000010", c, addr); end
            vectors++; if (wb_rw !== 1'b0) begin miscompares++; $display("FAIL sh_wait[%0d] wb_rw: got %b expected 0", c, wb_rw); end
            ack = (c == 2);
            #1;
            vectors++; if (stall !== (c != 2)) begin miscompares++; $display("FAIL sh_wait[%0d] stall: got %b expected %b", c, stall, c != 2); end
            @(posedge clk); #1;
        end
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL sh_wait done req: got %b expected 0", req); end
        vectors++; if (wb_rw !== 1'b0) begin miscompares++; $display("FAIL sh_wait done wb_rw: got %b expected 0", wb_rw); end
        @(negedge clk);
        ack = 1'b0;
        clear_inputs();
    endtask

    task automatic test_misalign();
        @(negedge clk);
        alu_result = 32'h102; rd = 5'd9; mem_read = 2'b01; reg_write = 1'b1; mem_to_reg = 1'b1;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL mis_lw stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL mis_lw req: got %b expected 0", req); end
        vectors++; if (misalign !== 1'b1) begin miscompares++; $display("FAIL mis_lw pulse: got %b expected 1", misalign); end
        vectors++; if (wb_rw !== 1'b0) begin miscompares++; $display("FAIL mis_lw wb_rw: got %b expected 0", wb_rw); end
        @(negedge clk);
        clear_inputs();
        alu_result = 32'h13; b = 32'h5555; mem_write = 2'b10; rd = 5'd2;
        @(posedge clk); #1;
        vectors++; if (misalign !== 1'b1) begin miscompares++; $display("FAIL mis_sh pulse: got %b expected 1", misalign); end
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL mis_sh req: got %b expected 0", req); end
        @(negedge clk);
        clear_inputs();
        alu_result = 32'h55; rd = 5'd0; reg_write = 1'b1;
        @(posedge clk); #1;
        vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL mis one-shot: got %b expected 0", misalign); end
        vectors++; if (wb_rw !== 1'b0) begin miscompares++; $display("FAIL addi_r0 wb_rw: got %b expected 0", wb_rw); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL addi_r0 stall: got %b expected 0", stall); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_precedence();
        @(negedge clk);
        alu_result = 32'h101; b = 32'hFFFF_FFFF; rd = 5'd8;
        mem_read = 2'b11; mem_write = 2'b01; reg_write = 1'b1; mem_to_reg = 1'b1; ack = 1'b0;
        @(posedge clk); #1;
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL prec we: got %b expected 0", we); end
        vectors++; if (be !== 4'b0100) begin miscompares++; $display("FAIL prec be: got %b expected 0100", be); end
        ack = 1'b1; rdata = 32'hAA55CC33;
        @(posedge clk); #1;
        vectors++; if (wb_data !== 32'h00000055) begin miscompares++; $display("FAIL prec wb_data: got %h expected 00000055", wb_data); end
        vectors++; if (wb_rw !== 1'b1) begin miscompares++; $display("FAIL prec wb_rw: got %b expected 1", wb_rw); end
        @(negedge clk);
        ack = 1'b0;
        clear_inputs();
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        alu_result = 32'h0000_1234; rd = 5'd5; reg_write = 1'b1;
        @(negedge clk);
        alu_result = 32'h40; rd = 5'd4; mem_read = 2'b01; reg_write = 1'b1; mem_to_reg = 1'b1; ack = 1'b0;
        @(posedge clk); #1;
        vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL rst_mid pre req: got %b expected 1", req); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL rst_mid req: got %b expected 0", req); end
        vectors++; if (wb_addr !== 5'd0) begin miscompares++; $display("FAIL rst_mid wb_addr: got %0d expected 0", wb_addr); end
        vectors++; if (wb_data !== 32'h0) begin miscompares++; $display("FAIL rst_mid wb_data: got %h expected 0", wb_data); end
        vectors++; if (wb_rw !== 1'b0) begin miscompares++; $display("FAIL rst_mid wb_rw: got %b expected 0", wb_rw); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_mid stall: got %b expected 0", stall); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        alu_result = 32'h77; rd = 5'd6; reg_write = 1'b1;
        ack = 1'b1; rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        vectors++; if (wb_data !== 32'h77) begin miscompares++; $display("FAIL late_ack wb_data: got %h expected 00000077", wb_data); end
        vectors++; if (wb_addr !== 5'd6) begin miscompares++; $display("FAIL late_ack wb_addr: got %0d expected 6", wb_addr); end
        vectors++; if (wb_rw !== 1'b1) begin miscompares++; $display("FAIL late_ack wb_rw: got %b expected 1", wb_rw); end
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL late_ack req: got %b expected 0", req); end
        @(negedge clk);
        ack = 1'b0;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        alu_result = 32'h80; rd = 5'd2; mem_read = 2'b01; reg_write = 1'b1; mem_to_reg = 1'b1;
        @(posedge clk); #1;
        ack = 1'b1; rdata = 32'h01020304;
        @(posedge clk); #1;
        vectors++; if (wb_data !== 32'h01020304) begin miscompares++; $display("FAIL b2b ld wb_data: got %h expected 01020304", wb_data); end
        @(negedge clk);
        ack = 1'b0;
        clear_inputs();
        alu_result = 32'h99; rd = 5'd3; reg_write = 1'b1;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL b2b alu stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        vectors++; if (wb_data !== 32'h99) begin miscompares++; $display("FAIL b2b alu wb_data: got %h expected 00000099", wb_data); end
        vectors++; if (wb_addr !== 5'd3) begin miscompares++; $display("FAIL b2b alu wb_addr: got %0d expected 3", wb_addr); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_loads();
        test_stores();
        test_store_wait();
        test_misalign();
        test_precedence();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
